// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
package alu_pkg;

  // Controller state encoding; values are fixed so external checkers can
  // decode the debug state output directly.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] S_IDLE_ENC = 2'd0;
  localparam logic [1:0] S_RUN_ENC  = 2'd1;
  localparam logic [1:0] S_DONE_ENC = 2'd2;

  // Carry seeded into bit 0: two's-complement subtract is a + ~b + 1.
  function automatic logic initial_carry(input logic sub, input logic cin);
    return sub ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/adder.sv
// One-bit full-adder cell shared by the serial datapath.
module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Plain full-adder equations.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer around a single full-adder cell.
// Operands are shifted LSB first, one bit per clock; the result is shifted
// in from the MSB side so that after WIDTH bits it sits right-aligned.
//
// Handshake: start is sampled only in IDLE or DONE; the edge that samples
// start=1 latches a/b/cin/sub and raises busy. busy stays high for exactly
// WIDTH cycles, then done pulses for one cycle with sum/cout/ovf valid.
// start during the DONE cycle begins the next operation with no gap.
module serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_co;

  // The single full-adder cell always sees the current LSBs and carry.
  adder u_adder (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = initial_carry(sub, cin);
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        // start is deliberately ignored here: operands must not change.
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB at this point.
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    busy      = busy_q;
    done      = done_q;
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a result scoreboard.
module tb_serial_add_ctrl;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int EW    = WIDTH + 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [1:0]       state_dbg;

  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            cyc;
  int            n_total;
  int            n_pass;
  int            busy_run;
  logic          prev_done;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Driver: called just after a negedge; start is seen at the next posedge.
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic cv, input logic sv,
                       input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    a     = av;
    b     = bv;
    cin   = cv;
    sub   = sv;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({es, ec, eo});
    lat_q.push_back(cyc + WIDTH);
    start = 1'b0;
  endtask

  // Bounded wait until done is visible at a negedge.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * WIDTH; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: compares every done against the scoreboard head.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            l;
    if (rst) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          check("result_sum_cout_ovf", 64'({sum, cout, ovf}), 64'(e));
          check("done_latency", 64'(cyc), 64'(l));
        end
        check("busy_cycles", 64'(busy_run), 64'(WIDTH));
        check("done_single_pulse", 64'(prev_done), 64'd0);
        busy_run = 0;
      end
      prev_done = done;
    end
  end

  // Directed stimulus.
  initial begin
    cyc       = 0;
    n_total   = 0;
    n_pass    = 0;
    busy_run  = 0;
    prev_done = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    sub       = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #1;
    check("reset_outputs", 64'({busy, done, sum, cout, ovf}), 64'd0);
    check("reset_state", 64'(state_dbg), 64'(S_IDLE_ENC));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Plain adds, including carry-in and both overflow directions.
    issue(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    wait_done();
    repeat ($urandom_range(1, 3)) @(negedge clk);
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    wait_done();
    repeat ($urandom_range(1, 3)) @(negedge clk);
    issue(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    wait_done();
    @(negedge clk);

    // Subtracts: cin must be ignored.
    issue(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    wait_done();
    @(negedge clk);
    issue(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    wait_done();
    @(negedge clk);
    issue(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    wait_done();
    @(negedge clk);

    // start pulsed mid-RUN must not disturb the operation.
    issue(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Back-to-back: start held during the done cycle.
    issue(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    check("busy_after_b2b_start", 64'(busy), 64'd1);
    wait_done();
    @(negedge clk);

    // Reset in the middle of RUN aborts with no done pulse.
    issue(8'h55, 8'h11, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_reset_outputs", 64'({busy, done, sum, cout, ovf}), 64'd0);
    check("midrun_reset_state", 64'(state_dbg), 64'(S_IDLE_ENC));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (WIDTH + 2) @(negedge clk);
    check("no_done_after_abort", 64'(done), 64'd0);
    issue(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
    wait_done();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
